// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: the PC, the IF/ID and ID/EX stages, and a bubble counter.
// The stall, flush and redirect inputs act only at the clock edge. pc_plus4_f is the only combinational output.
module pipe_front_regs (
  input  logic        clk,
  input  logic        reset,
  // hazard control
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        flush_e,
  // redirect
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  // fetch
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  // IF/ID
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  // decode
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] imm_ext_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        regwrite_d,
  input  logic        memwrite_d,
  input  logic        jump_d,
  input  logic        branch_d,
  input  logic        alu_src_d,
  input  logic [1:0]  result_src_d,
  input  logic [2:0]  alu_ctrl_d,
  // ID/EX
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_ext_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e,
  output logic        regwrite_e,
  output logic        memwrite_e,
  output logic        jump_e,
  output logic        branch_e,
  output logic        alu_src_e,
  output logic [1:0]  result_src_e,
  output logic [2:0]  alu_ctrl_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic        valid_e,
  output logic [15:0] bubble_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam logic [XLEN-1:0]  NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic            bubble_e;

  assign pc_plus4_f = pc_f + XLEN'(4);
  assign pc_next    = pc_src_e ? pc_target_e : pc_plus4_f;
  // A redirect must not be lost, so it loads the PC even while fetch is stalled.
  assign pc_load    = ~stall_f | pc_src_e;
  assign bubble_e   = flush_e | ~valid_d;

  // Program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= '0;
    end else if (pc_load) begin
      pc_f <= pc_next;
    end
  end

  // IF/ID register; flush takes priority over stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

  // ID/EX register; it either loads or clears on every edge and never holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_ext_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      regwrite_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alu_src_e    <= 1'b0;
      result_src_e <= '0;
      alu_ctrl_e   <= '0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      valid_e      <= 1'b0;
    end else if (flush_e) begin
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_ext_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      regwrite_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alu_src_e    <= 1'b0;
      result_src_e <= '0;
      alu_ctrl_e   <= '0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      valid_e      <= 1'b0;
    end else begin
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      imm_ext_e    <= imm_ext_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
      regwrite_e   <= regwrite_d;
      memwrite_e   <= memwrite_d;
      jump_e       <= jump_d;
      branch_e     <= branch_d;
      alu_src_e    <= alu_src_d;
      result_src_e <= result_src_d;
      alu_ctrl_e   <= alu_ctrl_d;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
      valid_e      <= valid_d;
    end
  end

  // Counts edges where ID/EX receives a bubble: a flush, or an invalid IF/ID slot. Saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (bubble_e && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: a vector table for the pipeline flow and hand sequences for reset and saturation.
module tb_pipe_front_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, flush_e, pc_src_e;
  logic [31:0] pc_target_e, instr_f, pc_f, pc_plus4_f;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_ctrl_d;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e, valid_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_ctrl_e;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_front_regs dut (
    .clk(clk), .reset(reset),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .instr_f(instr_f), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .jump_d(jump_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d),
    .result_src_d(result_src_d), .alu_ctrl_d(alu_ctrl_d),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .jump_e(jump_e),
    .branch_e(branch_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .valid_e(valid_e),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        sf, sd, fd, fe, ps;
    logic [31:0] tgt, instr;
    logic [4:0]  rd;
    logic [31:0] e_pc, e_pc4, e_pcd, e_instr;
    logic        e_vd, e_ve, e_rw;
    logic [4:0]  e_rd;
    logic [15:0] e_bub;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
    pc_src_e = 1'b0; pc_target_e = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pc_f"}, pc_f, 32'h0);
    chk({tag, " pc_plus4_f"}, pc_plus4_f, 32'h4);
    chk({tag, " instr_d"}, instr_d, 32'h0000_0013);
    chk({tag, " pc_d"}, pc_d, 32'h0);
    chk({tag, " pc_plus4_d"}, pc_plus4_d, 32'h0);
    chk({tag, " valid_d"}, 32'(valid_d), 32'h0);
    chk({tag, " rd1_e"}, rd1_e, 32'h0);
    chk({tag, " imm_ext_e"}, imm_ext_e, 32'h0);
    chk({tag, " rd_e"}, 32'(rd_e), 32'h0);
    chk({tag, " ctrl_e"}, 32'({regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e,
                               result_src_e, alu_ctrl_e}), 32'h0);
    chk({tag, " pc_e"}, pc_e, 32'h0);
    chk({tag, " valid_e"}, 32'(valid_e), 32'h0);
    chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'h0);
  endtask

  initial begin
    // sf sd fd fe ps  tgt  instr  rd | pc  pc4  pc_d  instr_d  vd ve rw  rd_e  bub
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h00500093, 5'd1,
                 32'h4, 32'h8, 32'h0, 32'h00500093, 1'b1,1'b0,1'b1, 5'd1, 16'd1};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h00500093, 5'd2,
                 32'h8, 32'hC, 32'h4, 32'h00500093, 1'b1,1'b1,1'b1, 5'd2, 16'd1};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h00A00113, 5'd3,
                 32'hC, 32'h10, 32'h8, 32'h00A00113, 1'b1,1'b1,1'b1, 5'd3, 16'd1};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h00000213, 5'd4,
                 32'h10, 32'h14, 32'hC, 32'h00000213, 1'b1,1'b1,1'b1, 5'd4, 16'd1};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 32'h0, 32'hDEADBEEF, 5'd5,
                 32'h10, 32'h14, 32'hC, 32'h00000213, 1'b1,1'b0,1'b0, 5'd0, 16'd2};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h00C00193, 5'd6,
                 32'h14, 32'h18, 32'h10, 32'h00C00193, 1'b1,1'b1,1'b1, 5'd6, 16'd2};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 32'h40, 32'h11111111, 5'd7,
                 32'h40, 32'h44, 32'h0, 32'h00000013, 1'b0,1'b0,1'b0, 5'd0, 16'd3};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h22222222, 5'd8,
                 32'h44, 32'h48, 32'h40, 32'h22222222, 1'b1,1'b0,1'b1, 5'd8, 16'd4};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b1, 32'h80, 32'hAAAAAAAA, 5'd9,
                 32'h80, 32'h84, 32'h0, 32'h00000013, 1'b0,1'b0,1'b0, 5'd0, 16'd5};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h33333333, 5'd10,
                 32'h80, 32'h84, 32'h80, 32'h33333333, 1'b1,1'b0,1'b1, 5'd10, 16'd6};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0, 32'h44444444, 5'd11,
                 32'h84, 32'h88, 32'h80, 32'h33333333, 1'b1,1'b1,1'b1, 5'd11, 16'd6};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 32'hFFFFFFFC, 32'h55555555, 5'd12,
                 32'hFFFFFFFC, 32'h0, 32'h84, 32'h55555555, 1'b1,1'b1,1'b1, 5'd12, 16'd6};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h66666666, 5'd13,
                 32'h0, 32'h4, 32'hFFFFFFFC, 32'h66666666, 1'b1,1'b1,1'b1, 5'd13, 16'd6};

    reset = 1'b1;
    idle_inputs();
    instr_f = 32'h00500093;
    rd1_d = 32'h1111; rd2_d = 32'h2222; imm_ext_d = 32'h0; rs1_d = 5'd3; rs2_d = 5'd4; rd_d = '0;
    regwrite_d = 1'b1; memwrite_d = 1'b0; jump_d = 1'b0; branch_d = 1'b0; alu_src_d = 1'b1;
    result_src_d = 2'b01; alu_ctrl_d = 3'b010;
    step();
    step();
    chk_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      stall_f = vecs[i].sf; stall_d = vecs[i].sd; flush_d = vecs[i].fd; flush_e = vecs[i].fe;
      pc_src_e = vecs[i].ps; pc_target_e = vecs[i].tgt; instr_f = vecs[i].instr; rd_d = vecs[i].rd;
      step();
      chk($sformatf("v%0d pc_f", i), pc_f, vecs[i].e_pc);
      chk($sformatf("v%0d pc_plus4_f", i), pc_plus4_f, vecs[i].e_pc4);
      chk($sformatf("v%0d pc_d", i), pc_d, vecs[i].e_pcd);
      chk($sformatf("v%0d instr_d", i), instr_d, vecs[i].e_instr);
      chk($sformatf("v%0d valid_d", i), 32'(valid_d), 32'(vecs[i].e_vd));
      chk($sformatf("v%0d valid_e", i), 32'(valid_e), 32'(vecs[i].e_ve));
      chk($sformatf("v%0d regwrite_e", i), 32'(regwrite_e), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d rd_e", i), 32'(rd_e), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d bubble_cnt", i), 32'(bubble_cnt), 32'(vecs[i].e_bub));
    end

    // ID/EX picks up the IF/ID pc fields and the decode data, then a flush clears them
    idle_inputs();
    imm_ext_d = 32'h0000_0ABC;
    step();
    chk("idex pc_e", pc_e, 32'hFFFFFFFC);
    chk("idex pc_plus4_e", pc_plus4_e, 32'h0);
    chk("idex imm_ext_e", imm_ext_e, 32'h0000_0ABC);
    chk("idex rd2_e", rd2_e, 32'h2222);
    chk("idex ctrl_e", 32'({alu_src_e, result_src_e, alu_ctrl_e}), 32'b1_01_010);
    flush_e = 1'b1;
    step();
    chk("flush imm_ext_e", imm_ext_e, 32'h0);
    chk("flush pc_e", pc_e, 32'h0);
    chk("flush ctrl_e", 32'({alu_src_e, result_src_e, alu_ctrl_e}), 32'h0);

    // reset raised between edges while stalled and flushing
    stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
    step();
    #2 reset = 1'b1;
    #1;
    chk_reset_state("async");
    step();
    chk_reset_state("held");
    idle_inputs();
    #1 reset = 1'b0;
    instr_f = 32'h00700393;
    step();
    chk("post pc_f", pc_f, 32'h4);
    chk("post instr_d", instr_d, 32'h00700393);
    chk("post valid_d", 32'(valid_d), 32'h1);
    chk("post bubble_cnt", 32'(bubble_cnt), 32'h1);

    // saturation of the bubble counter
    flush_e = 1'b1;
    for (int i = 0; i < 65533; i++) step();
    chk("sat FFFE", 32'(bubble_cnt), 32'hFFFE);
    step();
    chk("sat FFFF", 32'(bubble_cnt), 32'hFFFF);
    for (int i = 0; i < 6; i++) step();
    chk("sat hold", 32'(bubble_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; reset in 1, asynchronous, active-high.
REQ-002 SHALL have hazard-control inputs: stall_f in 1, hold PC; stall_d in 1, hold IF/ID; flush_d in 1, clear IF/ID; flush_e in 1, clear ID/EX.
REQ-003 SHALL have redirect inputs: pc_src_e in 1, take redirect; pc_target_e in 32, redirect address.
REQ-004 SHALL have fetch-side ports: instr_f in 32, fetched word; pc_f out 32; pc_plus4_f out 32.
REQ-005 SHALL have IF/ID outputs: instr_d out 32; pc_d out 32; pc_plus4_d out 32; valid_d out 1.
REQ-006 SHALL have decode inputs: rd1_d, rd2_d, imm_ext_d in 32 each; rs1_d, rs2_d, rd_d in 5 each; regwrite_d, memwrite_d, jump_d, branch_d, alu_src_d in 1 each; result_src_d in 2; alu_ctrl_d in 3.
REQ-007 SHALL have ID/EX outputs: the same fields with suffix _e, plus pc_e, pc_plus4_e (32 each) and valid_e (1).
REQ-008 SHALL have bubble_cnt out 16, count of cycles ID/EX loaded a bubble.

Function
REQ-009 pc_plus4_f SHALL be combinational pc_f + 4, modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-010 PC next: pc_src_e=1 -> pc_target_e; else pc_plus4_f.
REQ-011 PC update: stall_f=0 -> load next PC at posedge; stall_f=1 -> hold, unless pc_src_e=1, which SHALL override stall and load pc_target_e.
REQ-012 IF/ID priority per posedge: flush_d=1 -> instr_d=0x00000013 (addi x0,x0,0), pc_d=0, pc_plus4_d=0, valid_d=0; else stall_d=1 -> hold all fields; else load instr_f, pc_f, pc_plus4_f, valid_d=1.
REQ-013 flush_d SHALL win over stall_d when both asserted.
REQ-014 ID/EX per posedge: flush_e=1 -> regwrite_e, memwrite_e, jump_e, branch_e, alu_src_e=0, result_src_e=2'b00, alu_ctrl_e=3'b000, rs1_e=rs2_e=rd_e=0, valid_e=0, data fields 0; else load all _d values, valid_e=valid_d.
REQ-015 ID/EX SHALL have no stall; it loads or clears every cycle.
REQ-016 bubble_cnt SHALL increment by 1 each posedge where flush_e=1 or (flush_e=0 and valid_d=0); it SHALL saturate at 0xFFFF.
REQ-017 Latency: instr_f sampled at edge N appears on instr_d after edge N, and its decode fields on _e outputs after edge N+1, absent stall/flush.
REQ-018 All registered outputs SHALL change only at posedge clk or on reset; no combinational path from stall/flush inputs to outputs except via pc_plus4_f from pc_f.

Reset
REQ-019 reset=1 SHALL immediately force pc_f=0x00000000, instr_d=0x00000013, pc_d=pc_plus4_d=0, valid_d=0, all ID/EX fields 0, valid_e=0, bubble_cnt=0.
REQ-020 First posedge after reset deassert SHALL load pc_f=0x00000004 (no stall/redirect) and instr_d=instr_f, valid_d=1.
REQ-021 Reset asserted mid-stall or mid-flush SHALL override all inputs; state SHALL equal REQ-019 values.

Verification
REQ-022 Straight-line: reset, release, instr_f=0x00500093 each cycle -> pc_f 0,4,8,0xC; instr_d=0x00500093 after edge 1; rd_e=rd_d one edge later; bubble_cnt stays at post-reset bubble count 1.
REQ-023 Load-use: stall_f=stall_d=flush_e=1 for one cycle at pc_f=0x10 -> pc_f holds 0x10, instr_d held, valid_e=0 and regwrite_e=0 next cycle, bubble_cnt +1.
REQ-024 Branch taken: pc_src_e=1, pc_target_e=0x40, flush_d=flush_e=1 -> pc_f=0x40, instr_d=0x00000013, valid_d=0, valid_e=0; bubble_cnt +1 that edge, +1 next edge.
REQ-025 Simultaneous: stall_f=stall_d=1 with pc_src_e=flush_d=flush_e=1 -> pc_f=pc_target_e, IF/ID cleared (flush wins).
REQ-026 Wrap and saturation: pc_f=0xFFFFFFFC, no stall -> pc_f=0x00000000; force 65540 consecutive flush_e cycles -> bubble_cnt=0xFFFF and holds.
REQ-027 Async reset: assert reset between clock edges during stall -> all outputs take REQ-019 values before next posedge.
